// File: rtl/audio_output.sv
// audio_output: playback-side PWM DAC driver.
// Takes signed samples from the effect chain, rounds and saturates them to the
// PWM resolution and converts them to offset binary. It holds one sample in
// reserve and swaps it in at each PWM frame boundary. A frame with no fresh
// sample repeats the previous duty cycle and reports an underrun.
`timescale 1ns/1ps

module audio_output #(
    parameter int bit_depth    = 10,
    parameter int target_depth = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [target_depth-1:0] i_sample,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic                           o_frame_start,
    output logic                           o_pwm,
    output logic                           o_underrun,
    output logic [15:0]                    o_underrun_cnt
);

    // Number of LSBs dropped when narrowing a sample to the PWM resolution.
    localparam int SHIFT = target_depth - bit_depth;

    // Last count of a frame; the boundary actions happen in this cycle.
    localparam logic [bit_depth-1:0] CNT_LAST = '1;

    // Midscale duty: the PWM equivalent of silence.
    localparam logic [bit_depth-1:0] MIDSCALE = bit_depth'(1 << (bit_depth - 1));

    // Half an output LSB. Adding it before truncation rounds to nearest.
    localparam logic signed [target_depth:0] ROUND_BIAS =
        (target_depth + 1)'(1 << (SHIFT - 1));

    // Largest positive code at the output resolution.
    localparam logic signed [bit_depth:0] POS_MAX =
        (bit_depth + 1)'((1 << (bit_depth - 1)) - 1);

    localparam logic [15:0] UCNT_MAX = 16'hFFFF;

    // Reject configurations the conversion datapath cannot represent.
    generate
        if (target_depth <= bit_depth) begin : g_bad_target_depth
            $error("audio_output: target_depth must be greater than bit_depth");
        end
        if (bit_depth < 2) begin : g_bad_bit_depth
            $error("audio_output: bit_depth must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [bit_depth-1:0] cnt_q,          cnt_d;
    logic [bit_depth-1:0] duty_q,         duty_d;
    logic [bit_depth-1:0] hold_q,         hold_d;
    logic                 hold_full_q,    hold_full_d;
    logic                 pwm_q,          pwm_d;
    logic                 frame_start_q,  frame_start_d;
    logic                 underrun_q,     underrun_d;
    logic [15:0]          underrun_cnt_q, underrun_cnt_d;

    // ------------------------------------------------------------------
    // Conversion datapath
    // ------------------------------------------------------------------
    logic signed [target_depth:0] ext_s;
    logic signed [target_depth:0] biased_s;
    logic signed [bit_depth:0]    rounded_s;
    logic signed [bit_depth:0]    sat_s;
    logic [bit_depth-1:0]         conv_code;

    // The rounding step discards these bits by design.
    logic unused_bits;

    logic boundary;
    logic accept;

    // Round, saturate and offset-bin the incoming sample.
    always_comb begin
        // One extra bit of headroom, so the rounding bias cannot overflow.
        ext_s     = {i_sample[target_depth-1], i_sample};
        biased_s  = ext_s + ROUND_BIAS;
        // Taking bits [target_depth:SHIFT] of a signed value is the same as an
        // arithmetic right shift by SHIFT followed by truncation to bit_depth+1.
        rounded_s = biased_s[target_depth:SHIFT];
        // Only the top input codes round up past the positive limit. The most
        // negative input lands exactly on -2^(bit_depth-1), so no lower clamp.
        sat_s     = (rounded_s > POS_MAX) ? POS_MAX : rounded_s;
        // Inverting the sign bit turns two's complement into offset binary.
        conv_code = {~sat_s[bit_depth-1], sat_s[bit_depth-2:0]};
    end

    assign unused_bits = ^{biased_s[SHIFT-1:0], sat_s[bit_depth]};

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign boundary = (cnt_q == CNT_LAST);
    assign accept   = i_valid && !hold_full_q;
    assign o_ready  = !hold_full_q;

    // Next-state logic for the frame counter, the sample hold and the duty reload.
    always_comb begin
        // NOTE: every always_comb target gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        cnt_d          = cnt_q + bit_depth'(1);
        duty_d         = duty_q;
        hold_d         = hold_q;
        hold_full_d    = hold_full_q;
        underrun_cnt_d = underrun_cnt_q;
        frame_start_d  = boundary;
        underrun_d     = boundary && !hold_full_q;
        pwm_d          = (cnt_q < duty_q);

        // The duty changes only at a frame boundary, so a frame's pulse is
        // never split between two samples.
        if (boundary) begin
            if (hold_full_q) begin
                duty_d      = hold_q;
                hold_full_d = 1'b0;
            end else if (underrun_cnt_q != UCNT_MAX) begin
                underrun_cnt_d = underrun_cnt_q + 16'd1;
            end
        end

        // An accept in the boundary cycle cannot share that cycle's reload.
        // The hold was empty when the frame ended, so the sample waits for the
        // next boundary. While the hold is full, o_ready is low and accept
        // cannot fire, so this branch never collides with the reload above.
        if (accept) begin
            hold_d      = conv_code;
            hold_full_d = 1'b1;
        end
    end

    // State registers. Reset clears everything at once, including any held sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            duty_q         <= MIDSCALE;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            pwm_q          <= 1'b0;
            frame_start_q  <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from
            // the same pre-edge values, whatever the statement order.
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            pwm_q          <= pwm_d;
            frame_start_q  <= frame_start_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    // The PWM pin is driven straight from a flop, so there are no glitches on the RC filter.
    assign o_pwm          = pwm_q;
    assign o_frame_start  = frame_start_q;
    assign o_underrun     = underrun_q;
    assign o_underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_audio_output.sv
// tb_audio_output: directed bench for audio_output with a frame-level
// reference model and per-cycle comparison of every output.
`timescale 1ns/1ps

module tb_audio_output;

    localparam int BD    = 10;
    localparam int TD    = 16;
    localparam int FRAME = 1 << BD;
    localparam int HALF  = FRAME / 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] i_sample;
    logic               i_valid;
    logic               o_ready;
    logic               o_frame_start;
    logic               o_pwm;
    logic               o_underrun;
    logic [15:0]        o_underrun_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    audio_output #(
        .bit_depth    (BD),
        .target_depth (TD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_sample       (i_sample),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .o_frame_start  (o_frame_start),
        .o_pwm          (o_pwm),
        .o_underrun     (o_underrun),
        .o_underrun_cnt (o_underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: plain integer rounding, a one-deep sample queue,
    // and a cycle index since reset to locate frame boundaries.
    // ------------------------------------------------------------------
    int m_k    = 0;
    int m_duty = HALF;
    int m_ucnt = 0;
    int m_q[$];
    bit e_pwm   = 1'b0;
    bit e_fs    = 1'b0;
    bit e_under = 1'b0;

    function automatic int conv(input int v);
        int step;
        int num;
        int q;
        step = 1 << (TD - BD);
        num  = v + step / 2;
        if (num >= 0) q = num / step;
        else          q = -((-num + step - 1) / step);
        if (q > HALF - 1) q = HALF - 1;
        return q + HALF;
    endfunction

    always @(negedge rst_n) begin
        m_k    = 0;
        m_duty = HALF;
        m_ucnt = 0;
        m_q.delete();
        e_pwm   = 1'b0;
        e_fs    = 1'b0;
        e_under = 1'b0;
    end

    always @(posedge clk) begin
        int  pos;
        bit  at_end;
        bit  take;
        if (rst_n === 1'b1) begin
            pos     = m_k % FRAME;
            at_end  = (pos == FRAME - 1);
            take    = (i_valid === 1'b1) && (m_q.size() == 0);
            e_pwm   = (pos < m_duty);
            e_fs    = at_end;
            e_under = at_end && (m_q.size() == 0);
            if (at_end) begin
                if (m_q.size() != 0) m_duty = m_q.pop_front();
                else if (m_ucnt < 65535) m_ucnt++;
            end
            if (take) m_q.push_back(conv(int'(i_sample)));
            m_k++;
        end
    end

    // Compare all outputs against the model on every falling edge.
    always @(negedge clk) begin
        check("cmp_pwm",      o_pwm,          e_pwm);
        check("cmp_fs",       o_frame_start,  e_fs);
        check("cmp_underrun", o_underrun,     e_under);
        check("cmp_ucnt",     o_underrun_cnt, m_ucnt);
        check("cmp_ready",    o_ready,        m_q.size() == 0);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change only just after a falling edge.
    // ------------------------------------------------------------------
    task automatic present(input logic signed [15:0] v);
        i_sample = v;
        i_valid  = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) step();
    endtask

    // Starting at a frame's cnt==0 falling edge, count the high cycles of that frame.
    task automatic measure(output int high);
        high = 0;
        repeat (FRAME) begin
            step();
            if (o_pwm === 1'b1) high++;
        end
    endtask

    logic signed [15:0] vec [6] = '{16'sh0000, 16'sh0020, 16'sh001F,
                                    16'shFFDF, 16'sh7FFF, 16'sh8000};
    int                 vexp[6] = '{512, 513, 512, 511, 1023, 0};

    initial begin
        int h;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_sample = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm",      o_pwm,          0);
        check("rst_fs",       o_frame_start,  0);
        check("rst_underrun", o_underrun,     0);
        check("rst_ucnt",     o_underrun_cnt, 0);
        rst_n = 1'b1;
        #1 check("rst_ready_after_release", o_ready, 1);

        // Idle: midscale output and one underrun per frame.
        for (int f = 0; f < 3; f++) begin
            measure(h);
            check("idle_high",     h,             512);
            check("idle_fs",       o_frame_start, 1);
            check("idle_underrun", o_underrun,    1);
        end
        check("idle_ucnt", o_underrun_cnt, 3);

        // Conversion vectors. The next sample is loaded while the current one plays.
        present(vec[0]);
        run_cycles(FRAME);
        check("conv_align_fs", o_frame_start, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) present(vec[i+1]);
            measure(h);
            check($sformatf("conv_high_%0d", i), h, vexp[i]);
        end
        check("conv_ucnt", o_underrun_cnt, 4);

        // Handshake: one sample per frame; a second one in the same frame is ignored.
        present(16'sh0100);
        run_cycles(5);
        check("hs_busy", o_ready, 0);
        present(16'sh7FFF);
        run_cycles(FRAME - 5);
        check("hs_fs",          o_frame_start, 1);
        check("hs_no_underrun", o_underrun,    0);
        present(16'shFF00);
        measure(h);
        check("hs_first_kept",   h,          516);
        check("hs_no_underrun2", o_underrun, 0);
        measure(h);
        check("hs_second", h,              508);
        check("hs_ucnt",   o_underrun_cnt, 5);

        // Timing: accept at cnt=100. The duty holds until the boundary.
        run_cycles(100);
        check("tm_ready_before", o_ready, 1);
        present(16'sh4000);
        step();
        check("tm_ready_after", o_ready, 0);
        run_cycles(500);
        check("tm_duty_unchanged", o_pwm, 0);
        run_cycles(422);
        check("tm_ready_last_cycle", o_ready, 0);
        step();
        check("tm_ready_after_wrap", o_ready,       1);
        check("tm_fs",               o_frame_start, 1);
        check("tm_no_underrun",      o_underrun,    0);
        check("tm_pwm_lag_old",      o_pwm,         0);
        step();
        check("tm_pwm_lag_new", o_pwm, 1);
        h = 1;
        repeat (FRAME - 1) begin
            step();
            if (o_pwm === 1'b1) h++;
        end
        check("tm_high", h,              768);
        check("tm_ucnt", o_underrun_cnt, 6);

        // Boundary race: an accept in the cnt==1023 cycle misses this reload.
        run_cycles(FRAME - 1);
        check("race_ready", o_ready, 1);
        present(16'sh7FFF);
        step();
        check("race_underrun", o_underrun,     1);
        check("race_ucnt",     o_underrun_cnt, 7);
        check("race_held",     o_ready,        0);
        measure(h);
        check("race_prev_duty",   h,          768);
        check("race_no_underrun", o_underrun, 0);
        measure(h);
        check("race_new_duty", h,              1023);
        check("race_ucnt_end", o_underrun_cnt, 8);

        // Async reset mid-frame with a sample held.
        present(16'sh0000);
        run_cycles(200);
        check("ar_held", o_ready, 0);
        check("ar_pwm",  o_pwm,   1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_pwm_zero", o_pwm,          0);
        check("ar_fs",       o_frame_start,  0);
        check("ar_underrun", o_underrun,     0);
        check("ar_ucnt",     o_underrun_cnt, 0);
        check("ar_ready",    o_ready,        1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("ar_ready_release", o_ready, 1);
        measure(h);
        check("ar_midscale", h,              512);
        check("ar_underrun", o_underrun,     1);
        check("ar_ucnt_one", o_underrun_cnt, 1);

        // Saturation: preload the counter near full scale, then keep underrunning.
        #2;
        force dut.underrun_cnt_q = 16'hFFFD;
        m_ucnt = 16'hFFFD;
        #1;
        release dut.underrun_cnt_q;
        measure(h);
        check("sat_ucnt_1", o_underrun_cnt, 16'hFFFE);
        measure(h);
        check("sat_ucnt_2", o_underrun_cnt, 16'hFFFF);
        measure(h);
        check("sat_ucnt_3",     o_underrun_cnt, 16'hFFFF);
        check("sat_underrun_3", o_underrun,     1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Bound the whole run so a stuck design cannot hang the simulation.
    initial begin
        #(40000 * 10);
        $display("FAIL watchdog: run exceeded 40000 cycles, checks=%0d failures=%0d", n_checks, n_fails);
        $fatal(1, "timeout");
    end

endmodule
